// File: rtl/vai_pkg.sv
// rtl/vai_pkg.sv - CCI-P Tx request types, token type and request cost helper for the VAI Tx shaper
package vai_pkg;

   localparam int VAI_DEF_FIFO_DEPTH   = 16;
   localparam int VAI_MAX_BUCKET_DEPTH = 64;
   localparam int CCIP_CLADDR_W        = 42;
   localparam int CCIP_MDATA_W         = 16;
   localparam int CCIP_CLDATA_W        = 512;
   localparam int CCIP_MMIODATA_W      = 64;

   typedef logic [$clog2(VAI_MAX_BUCKET_DEPTH+1)-1:0] t_vai_token;

   typedef enum logic [1:0] {
      eREQ_WRLINE  = 2'd0,
      eREQ_WRFENCE = 2'd1
   } t_ccip_c1_req;

   typedef struct packed {
      logic [1:0]               cl_len;
      logic [CCIP_CLADDR_W-1:0] address;
      logic [CCIP_MDATA_W-1:0]  mdata;
   } t_ccip_c0_ReqHdr;

   typedef struct packed {
      t_ccip_c1_req             req_type;
      logic                     sop;
      logic [1:0]               cl_len;
      logic [CCIP_CLADDR_W-1:0] address;
      logic [CCIP_MDATA_W-1:0]  mdata;
   } t_ccip_c1_ReqHdr;

   typedef struct packed {
      logic            valid;
      t_ccip_c0_ReqHdr hdr;
   } t_if_ccip_c0_Tx;

   typedef struct packed {
      logic                     valid;
      t_ccip_c1_ReqHdr          hdr;
      logic [CCIP_CLDATA_W-1:0] data;
   } t_if_ccip_c1_Tx;

   typedef struct packed {
      logic                       valid;
      logic [8:0]                 tid;
      logic [CCIP_MMIODATA_W-1:0] data;
   } t_if_ccip_c2_Tx;

   typedef struct packed {
      t_if_ccip_c0_Tx c0;
      t_if_ccip_c1_Tx c1;
      t_if_ccip_c2_Tx c2;
   } t_if_ccip_Tx;

   typedef struct packed {
      t_ccip_c1_ReqHdr          hdr;
      logic [CCIP_CLDATA_W-1:0] data;
   } t_vai_c1_pkt;

   typedef struct packed {
      logic         is_write;
      t_ccip_c1_req req_type;
      logic [1:0]   cl_len;
   } t_vai_cost_hdr;

   // Reads cost every line they return; each write beat is one line; fences move no data.
   function automatic t_vai_token vai_tx_cost(input t_vai_cost_hdr hdr);
      if (!hdr.is_write)
         return t_vai_token'(hdr.cl_len) + t_vai_token'(1);
      else if (hdr.req_type == eREQ_WRFENCE)
         return '0;
      else
         return t_vai_token'(1);
   endfunction

endpackage

// File: rtl/vai_tx_shaper_chan.sv
// rtl/vai_tx_shaper_chan.sv - one shaped channel: request FIFO, token bucket, refill counter and egress register
module vai_tx_shaper_chan
   import vai_pkg::*;
#(
   parameter type T_PKT         = logic,
   parameter int  FIFO_DEPTH    = VAI_DEF_FIFO_DEPTH,
   parameter int  ALMFULL_SLACK = 8,
   parameter int  BUCKET_DEPTH  = 64,
   parameter int  INTERVAL_W    = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  T_PKT                  in_pkt,
   input  t_vai_token            in_cost,
   input  logic [INTERVAL_W-1:0] interval,
   input  logic                  up_almfull,
   output logic                  out_valid,
   output T_PKT                  out_pkt,
   output logic                  almfull,
   output logic                  overflow
);

   localparam int          AW         = $clog2(FIFO_DEPTH);
   localparam int          TW         = $bits(t_vai_token);
   localparam logic [AW:0] DEPTH      = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] ALM_THRESH = (AW+1)'(FIFO_DEPTH - ALMFULL_SLACK);
   localparam t_vai_token  TOKEN_MAX  = t_vai_token'(BUCKET_DEPTH);

   T_PKT                  pkt_mem  [FIFO_DEPTH];
   t_vai_token            cost_mem [FIFO_DEPTH];
   logic [AW:0]           wr_ptr;
   logic [AW:0]           rd_ptr;
   logic [AW:0]           count;
   logic                  full;
   logic                  empty;
   logic                  push;
   logic                  pop;
   t_vai_token            tokens;
   t_vai_token            head_cost;
   t_vai_token            spend;
   logic [TW:0]           token_sum;
   logic [INTERVAL_W-1:0] refill_cnt;
   logic [INTERVAL_W-1:0] interval_q;
   logic                  unlimited;
   logic                  cfg_change;
   logic                  refill;

   assign count     = wr_ptr - rd_ptr;
   assign full      = (count == DEPTH);
   assign empty     = (count == '0);
   assign push      = in_valid && !full;
   assign head_cost = cost_mem[rd_ptr[AW-1:0]];
   assign unlimited = (interval == '0);
   assign pop       = !empty && !up_almfull && (unlimited || tokens >= head_cost);

   // A new interval restarts the counter rather than waiting out the old period.
   assign cfg_change = (interval != interval_q);
   assign refill     = !unlimited && !cfg_change && (refill_cnt == interval - INTERVAL_W'(1));
   assign spend      = pop ? head_cost : '0;
   assign token_sum  = {1'b0, tokens} + {{TW{1'b0}}, refill} - {1'b0, spend};

   always_ff @(posedge clk) begin
      if (push) begin
         pkt_mem[wr_ptr[AW-1:0]]  <= in_pkt;
         cost_mem[wr_ptr[AW-1:0]] <= in_cost;
      end
      if (pop)
         out_pkt <= pkt_mem[rd_ptr[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         out_valid  <= 1'b0;
         almfull    <= 1'b0;
         overflow   <= 1'b0;
         tokens     <= TOKEN_MAX;
         refill_cnt <= '0;
         interval_q <= interval;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)
            rd_ptr <= rd_ptr + (AW+1)'(1);
         out_valid  <= pop;
         almfull    <= (count >= ALM_THRESH);
         if (in_valid && full)
            overflow <= 1'b1;
         interval_q <= interval;
         if (unlimited || cfg_change || refill)
            refill_cnt <= '0;
         else
            refill_cnt <= refill_cnt + INTERVAL_W'(1);
         if (unlimited || token_sum > {1'b0, TOKEN_MAX})
            tokens <= TOKEN_MAX;
         else
            tokens <= token_sum[TW-1:0];
      end
   end

endmodule

// File: rtl/vai_tx_shaper.sv
// rtl/vai_tx_shaper.sv - per-sub-AFU Tx shaper: token-bucket rate limit on c0/c1, registered c2 pass-through
module vai_tx_shaper
   import vai_pkg::*;
#(
   parameter int FIFO_DEPTH    = VAI_DEF_FIFO_DEPTH,
   parameter int ALMFULL_SLACK = 8,
   parameter int BUCKET_DEPTH  = 64,
   parameter int INTERVAL_W    = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  t_if_ccip_Tx           afu_TxPort,
   output logic                  afu_c0TxAlmFull,
   output logic                  afu_c1TxAlmFull,
   output t_if_ccip_Tx           up_TxPort,
   input  logic                  up_c0TxAlmFull,
   input  logic                  up_c1TxAlmFull,
   input  logic [INTERVAL_W-1:0] cfg_c0_interval,
   input  logic [INTERVAL_W-1:0] cfg_c1_interval,
   output logic                  overflow_err
);

   t_vai_cost_hdr   c0_cost_hdr;
   t_vai_cost_hdr   c1_cost_hdr;
   t_ccip_c0_ReqHdr c0_out_hdr;
   t_vai_c1_pkt     c1_in_pkt;
   t_vai_c1_pkt     c1_out_pkt;
   logic            c0_out_valid;
   logic            c1_out_valid;
   logic            c0_overflow;
   logic            c1_overflow;
   t_if_ccip_c2_Tx  c2_q;

   assign c0_cost_hdr = '{is_write: 1'b0, req_type: eREQ_WRLINE, cl_len: afu_TxPort.c0.hdr.cl_len};
   assign c1_cost_hdr = '{is_write: 1'b1, req_type: afu_TxPort.c1.hdr.req_type,
                          cl_len: afu_TxPort.c1.hdr.cl_len};
   assign c1_in_pkt   = '{hdr: afu_TxPort.c1.hdr, data: afu_TxPort.c1.data};

   vai_tx_shaper_chan #(
      .T_PKT         (t_ccip_c0_ReqHdr),
      .FIFO_DEPTH    (FIFO_DEPTH),
      .ALMFULL_SLACK (ALMFULL_SLACK),
      .BUCKET_DEPTH  (BUCKET_DEPTH),
      .INTERVAL_W    (INTERVAL_W)
   ) u_c0 (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (afu_TxPort.c0.valid),
      .in_pkt     (afu_TxPort.c0.hdr),
      .in_cost    (vai_tx_cost(c0_cost_hdr)),
      .interval   (cfg_c0_interval),
      .up_almfull (up_c0TxAlmFull),
      .out_valid  (c0_out_valid),
      .out_pkt    (c0_out_hdr),
      .almfull    (afu_c0TxAlmFull),
      .overflow   (c0_overflow)
   );

   vai_tx_shaper_chan #(
      .T_PKT         (t_vai_c1_pkt),
      .FIFO_DEPTH    (FIFO_DEPTH),
      .ALMFULL_SLACK (ALMFULL_SLACK),
      .BUCKET_DEPTH  (BUCKET_DEPTH),
      .INTERVAL_W    (INTERVAL_W)
   ) u_c1 (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (afu_TxPort.c1.valid),
      .in_pkt     (c1_in_pkt),
      .in_cost    (vai_tx_cost(c1_cost_hdr)),
      .interval   (cfg_c1_interval),
      .up_almfull (up_c1TxAlmFull),
      .out_valid  (c1_out_valid),
      .out_pkt    (c1_out_pkt),
      .almfull    (afu_c1TxAlmFull),
      .overflow   (c1_overflow)
   );

   // MMIO responses are never held back; they only get one register stage.
   always_ff @(posedge clk) begin
      if (reset)
         c2_q <= '0;
      else
         c2_q <= afu_TxPort.c2;
   end

   always_comb begin
      up_TxPort          = '0;
      up_TxPort.c0.valid = c0_out_valid;
      up_TxPort.c0.hdr   = c0_out_hdr;
      up_TxPort.c1.valid = c1_out_valid;
      up_TxPort.c1.hdr   = c1_out_pkt.hdr;
      up_TxPort.c1.data  = c1_out_pkt.data;
      up_TxPort.c2       = c2_q;
   end

   assign overflow_err = c0_overflow | c1_overflow;

endmodule

// File: tb/tb_vai_tx_shaper.sv
// tb/tb_vai_tx_shaper.sv - scoreboard and vector-table bench for vai_tx_shaper
module tb_vai_tx_shaper;
   import vai_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   t_if_ccip_Tx afu;
   t_if_ccip_Tx up;
   logic        afu_alm0, afu_alm1, up_alm0, up_alm1, ovf;
   logic [15:0] int0, int1;
   int          cyc = 0;
   int          tests = 0;
   int          fails = 0;

   typedef struct { t_ccip_c0_ReqHdr hdr; int due; } t_exp0;
   typedef struct { t_ccip_c1_ReqHdr hdr; logic [63:0] data; int due; } t_exp1;
   typedef struct { logic [8:0] tid; logic [63:0] data; int due; } t_exp2;
   typedef struct { int kind; logic [1:0] cl_len; logic [15:0] tag; logic [63:0] data; int lat; } t_vec;

   t_exp0 q0[$];
   t_exp1 q1[$];
   t_exp2 q2[$];
   int    t0[$];
   int    t1[$];

   vai_tx_shaper #(.FIFO_DEPTH(16), .ALMFULL_SLACK(8), .BUCKET_DEPTH(64), .INTERVAL_W(16)) dut (
      .clk             (clk),
      .reset           (reset),
      .afu_TxPort      (afu),
      .afu_c0TxAlmFull (afu_alm0),
      .afu_c1TxAlmFull (afu_alm1),
      .up_TxPort       (up),
      .up_c0TxAlmFull  (up_alm0),
      .up_c1TxAlmFull  (up_alm1),
      .cfg_c0_interval (int0),
      .cfg_c1_interval (int1),
      .overflow_err    (ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      t_exp0 e0;
      t_exp1 e1;
      t_exp2 e2;
      if (up.c0.valid === 1'b1) begin
         t0.push_back(cyc);
         if (q0.size() == 0) check("c0_unexpected_valid", 64'd1, 64'd0);
         else begin
            e0 = q0.pop_front();
            check("c0_hdr", 64'(up.c0.hdr), 64'(e0.hdr));
            if (e0.due >= 0) check("c0_latency", 64'(cyc), 64'(e0.due));
         end
      end
      if (up.c1.valid === 1'b1) begin
         t1.push_back(cyc);
         if (q1.size() == 0) check("c1_unexpected_valid", 64'd1, 64'd0);
         else begin
            e1 = q1.pop_front();
            check("c1_hdr", 64'(up.c1.hdr), 64'(e1.hdr));
            check("c1_data", up.c1.data[63:0], e1.data);
            if (e1.due >= 0) check("c1_latency", 64'(cyc), 64'(e1.due));
         end
      end
      if (up.c2.valid === 1'b1) begin
         if (q2.size() == 0) check("c2_unexpected_valid", 64'd1, 64'd0);
         else begin
            e2 = q2.pop_front();
            check("c2_tid", 64'(up.c2.tid), 64'(e2.tid));
            check("c2_data", up.c2.data, e2.data);
            if (e2.due >= 0) check("c2_latency", 64'(cyc), 64'(e2.due));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      afu.c0.valid = 1'b0;
      afu.c1.valid = 1'b0;
      afu.c2.valid = 1'b0;
   endtask

   task automatic drv_c0(input logic [1:0] cl_len, input logic [15:0] tag, input int lat, input logic keep);
      t_exp0 e;
      afu.c0.valid       = 1'b1;
      afu.c0.hdr.cl_len  = cl_len;
      afu.c0.hdr.address = 42'(tag) + 42'h1000;
      afu.c0.hdr.mdata   = tag;
      if (keep) begin
         e.hdr = afu.c0.hdr;
         e.due = (lat < 0) ? -1 : cyc + lat;
         q0.push_back(e);
      end
   endtask

   task automatic drv_c1(input logic fence, input logic [15:0] tag, input logic [63:0] data,
                         input int lat, input logic keep);
      t_exp1 e;
      afu.c1.valid        = 1'b1;
      afu.c1.hdr.req_type = fence ? eREQ_WRFENCE : eREQ_WRLINE;
      afu.c1.hdr.sop      = 1'b1;
      afu.c1.hdr.cl_len   = 2'd0;
      afu.c1.hdr.address  = 42'(tag) + 42'h2000;
      afu.c1.hdr.mdata    = tag;
      afu.c1.data         = 512'(data);
      if (keep) begin
         e.hdr  = afu.c1.hdr;
         e.data = data;
         e.due  = (lat < 0) ? -1 : cyc + lat;
         q1.push_back(e);
      end
   endtask

   task automatic drv_c2(input logic [8:0] tid, input logic [63:0] data, input int lat);
      t_exp2 e;
      afu.c2.valid = 1'b1;
      afu.c2.tid   = tid;
      afu.c2.data  = data;
      e.tid  = tid;
      e.data = data;
      e.due  = cyc + lat;
      q2.push_back(e);
   endtask

   task automatic wait_drain(input string name, input int limit);
      for (int k = 0; k < limit; k++) begin
         if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
         tick();
      end
      check(name, 64'(q0.size() + q1.size() + q2.size()), 64'd0);
   endtask

   task automatic wait_c0(input int target, input int limit);
      for (int k = 0; k < limit; k++) begin
         if (t0.size() >= target) break;
         tick();
      end
   endtask

   initial begin
      t_vec vec[6];
      int   pushed, bad, c, base;
      logic saw_alm;

      vec[0] = '{0, 2'd0, 16'h0011, 64'h0, 2};
      vec[1] = '{0, 2'd3, 16'h0012, 64'h0, 2};
      vec[2] = '{1, 2'd0, 16'h0021, 64'hdead_beef, 2};
      vec[3] = '{2, 2'd0, 16'h0022, 64'h0, 2};
      vec[4] = '{3, 2'd0, 16'h01a5, 64'h1234_5678_9abc_def0, 1};
      vec[5] = '{1, 2'd1, 16'h0023, 64'hcafe_f00d, 2};

      afu = '0; up_alm0 = 1'b0; up_alm1 = 1'b0; int0 = '0; int1 = '0; reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check("rst_c0_valid", 64'(up.c0.valid), 64'd0);
      check("rst_c1_valid", 64'(up.c1.valid), 64'd0);
      check("rst_c2_valid", 64'(up.c2.valid), 64'd0);
      check("rst_almfull", 64'({afu_alm0, afu_alm1}), 64'd0);
      check("rst_overflow", 64'(ovf), 64'd0);

      for (int i = 0; i < 6; i++) begin
         case (vec[i].kind)
            0: drv_c0(vec[i].cl_len, vec[i].tag, vec[i].lat, 1'b1);
            1: drv_c1(1'b0, vec[i].tag, vec[i].data, vec[i].lat, 1'b1);
            2: drv_c1(1'b1, vec[i].tag, vec[i].data, vec[i].lat, 1'b1);
            default: drv_c2(vec[i].tag[8:0], vec[i].data, vec[i].lat);
         endcase
         repeat (4) tick();
      end
      wait_drain("table_drain", 10);

      for (int i = 0; i < 10; i++) begin
         drv_c0(2'd0, 16'h0100 + 16'(i), 2, 1'b1);
         tick();
      end
      wait_drain("b2b_drain", 10);

      int1 = 16'd4;
      t1.delete();
      pushed = 0;
      saw_alm = 1'b0;
      for (int k = 0; k < 2000 && (pushed < 100 || q1.size() > 0); k++) begin
         if (afu_alm1) saw_alm = 1'b1;
         if (pushed < 100 && !afu_alm1) begin
            drv_c1(1'b0, 16'h0200 + 16'(pushed), 64'(pushed), -1, 1'b1);
            pushed++;
         end
         tick();
      end
      tick();
      check("rl_outputs", 64'(t1.size()), 64'd100);
      check("rl_saw_almfull", 64'(saw_alm), 64'd1);
      check("rl_no_overflow", 64'(ovf), 64'd0);
      if (t1.size() == 100) begin
         bad = 0;
         for (int i = 1; i < 64; i++) if (t1[i] - t1[i-1] != 1) bad++;
         check("rl_burst_gaps", 64'(bad), 64'd0);
         bad = 0;
         for (int i = 90; i < 100; i++) if (t1[i] - t1[i-1] != 4) bad++;
         check("rl_steady_gaps", 64'(bad), 64'd0);
      end
      int1 = '0;
      tick();

      int0 = 16'd1000;
      tick();
      t0.delete();
      for (int i = 0; i < 15; i++) begin
         drv_c0(2'd3, 16'h0300 + 16'(i), -1, 1'b1);
         tick();
      end
      drv_c0(2'd0, 16'h030f, -1, 1'b1);
      tick();
      drv_c0(2'd3, 16'h03ff, -1, 1'b1);
      tick();
      wait_c0(16, 40);
      repeat (30) tick();
      check("mc_head_held", 64'(t0.size()), 64'd16);
      int0 = 16'd10;
      c = cyc;
      wait_c0(17, 40);
      check("mc_release_count", 64'(t0.size()), 64'd17);
      if (t0.size() == 17) check("mc_release_cycle", 64'(t0[16]), 64'(c + 12));
      drv_c0(2'd0, 16'h03fe, -1, 1'b1);
      tick();
      wait_c0(18, 40);
      check("mc_next_count", 64'(t0.size()), 64'd18);
      if (t0.size() == 18) check("mc_tokens_zero", 64'(t0[17]), 64'(c + 22));
      int0 = '0;
      wait_drain("mc_drain", 10);

      up_alm0 = 1'b1;
      t0.delete();
      for (int i = 0; i < 5; i++) begin
         drv_c0(2'd1, 16'h0400 + 16'(i), -1, 1'b1);
         if (i < 3) drv_c1(1'b0, 16'h0500 + 16'(i), 64'h500 + 64'(i), 2, 1'b1);
         tick();
      end
      repeat (20) tick();
      check("bp_no_c0", 64'(t0.size()), 64'd0);
      check("bp_c1_flowed", 64'(q1.size()), 64'd0);
      up_alm0 = 1'b0;
      c = cyc;
      repeat (6) tick();
      check("bp_c0_count", 64'(t0.size()), 64'd5);
      if (t0.size() == 5) begin
         check("bp_first_cycle", 64'(t0[0]), 64'(c + 1));
         check("bp_last_cycle", 64'(t0[4]), 64'(c + 5));
      end

      up_alm1 = 1'b1;
      for (int i = 0; i < 17; i++) begin
         drv_c1(1'b0, 16'h0600 + 16'(i), 64'h600 + 64'(i), -1, i < 16);
         tick();
         check("ovf_almfull_timing", 64'(afu_alm1), 64'(i >= 8));
         check("ovf_flag_timing", 64'(ovf), 64'(i == 16));
      end
      repeat (5) tick();
      check("ovf_sticky_hold", 64'(ovf), 64'd1);
      up_alm1 = 1'b0;
      wait_drain("ovf_drain", 30);
      tick();
      check("ovf_sticky_after_drain", 64'(ovf), 64'd1);
      check("ovf_almfull_clear", 64'(afu_alm1), 64'd0);

      int0 = 16'd1000;
      tick();
      for (int i = 0; i < 16; i++) begin
         drv_c0(2'd3, 16'h0800 + 16'(i), -1, 1'b1);
         tick();
      end
      wait_drain("rs_token_drain", 30);
      up_alm0 = 1'b1;
      up_alm1 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drv_c1(1'b0, 16'h0700 + 16'(i), 64'(i), -1, 1'b0);
         if (i < 3) drv_c0(2'd0, 16'h0710 + 16'(i), -1, 1'b0);
         tick();
      end
      tick();
      check("rs_almfull_before", 64'(afu_alm1), 64'd1);
      reset = 1'b1;
      tick();
      check("rs_valids", 64'({up.c0.valid, up.c1.valid, up.c2.valid}), 64'd0);
      check("rs_almfull", 64'({afu_alm0, afu_alm1}), 64'd0);
      check("rs_overflow", 64'(ovf), 64'd0);
      tick();
      reset = 1'b0;
      up_alm0 = 1'b0;
      up_alm1 = 1'b0;
      base = t0.size() + t1.size();
      repeat (30) tick();
      check("rs_no_stale", 64'(t0.size() + t1.size()), 64'(base));
      for (int i = 0; i < 4; i++) begin
         drv_c0(2'd3, 16'h0900 + 16'(i), 2, 1'b1);
         tick();
      end
      wait_drain("rs_tokens_refilled", 10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
